byte_fifo_controller: RTL

Single-clock 512×8 byte FIFO controller that sequences one `dual_port_memory` instance: owns the write and read pointers, drives both memory ports, and presents valid/ready streams on each side. It sits between a byte producer (e.g. a serial receiver) and a consumer running on the same clock. Reads are prefetched so that `out_data` is the memory's registered read output, sustaining one byte per cycle with no bubbles.

---
 rtl/byte_fifo_defs_pkg.sv | 32 +++
 rtl/dual_port_memory.sv | 35 +++
 rtl/byte_fifo_controller.sv | 114 +++++++++++
 3 files changed

// File: rtl/byte_fifo_defs_pkg.sv
// Shared sizing, state types and helpers for the 512x8 byte FIFO controller
// and its dual-port memory.
package byte_fifo_defs;

    localparam int BYTE_FIFO_DEPTH       = 512;
    localparam int BYTE_FIFO_ADDR_WIDTH  = 9;
    localparam int BYTE_FIFO_DATA_WIDTH  = 8;
    localparam int BYTE_FIFO_LEVEL_WIDTH = 10;

    typedef logic [BYTE_FIFO_ADDR_WIDTH-1:0]  fifo_ptr_t;
    typedef logic [BYTE_FIFO_LEVEL_WIDTH-1:0] fifo_count_t;
    typedef logic [BYTE_FIFO_DATA_WIDTH-1:0]  fifo_byte_t;

    localparam fifo_ptr_t   PTR_ONE         = fifo_ptr_t'(1);
    localparam fifo_count_t COUNT_ONE       = fifo_count_t'(1);
    localparam fifo_count_t FIFO_FULL_COUNT = fifo_count_t'(BYTE_FIFO_DEPTH);

    // Everything the controller remembers between cycles, updated as one unit.
    typedef struct packed {
        fifo_ptr_t   wr_ptr;
        fifo_ptr_t   rd_ptr;
        fifo_count_t ram_count;
        logic        out_valid;
    } fifo_state_t;

    // Bytes held overall: those still in RAM plus the one parked at the head.
    function automatic fifo_count_t fifo_level(input fifo_count_t ram_count,
                                               input logic        head_valid);
        return ram_count + fifo_count_t'(head_valid);
    endfunction

endpackage

// File: rtl/dual_port_memory.sv
// Simple dual-port RAM: one write port, one read port with a registered
// output, each on its own clock and clock enable.
module dual_port_memory #(
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  write_clock,
    input  logic                  write_clock_enable,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_clock,
    input  logic                  read_clock_enable,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge write_clock) begin
        if (write_clock_enable && write_enable) begin
            mem[write_addr] <= write_data;
        end
    end

    // The read register holds its value until the next enabled read.
    always_ff @(posedge read_clock) begin
        if (read_clock_enable && read_enable) begin
            read_data <= mem[read_addr];
        end
    end

endmodule

// File: rtl/byte_fifo_controller.sv
// 512x8 byte FIFO controller with a prefetched head byte (513-byte capacity).
// Define BYTE_FIFO_LEVEL_EN to add the level/almost_full outputs.
module byte_fifo_controller
    import byte_fifo_defs::*;
`ifdef BYTE_FIFO_LEVEL_EN
#(
    parameter int ALMOST_FULL_LEVEL = 448
)
`endif
(
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            flush,
    input  logic [BYTE_FIFO_DATA_WIDTH-1:0] in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [BYTE_FIFO_DATA_WIDTH-1:0] out_data,
    output logic                            out_valid,
    input  logic                            out_ready
`ifdef BYTE_FIFO_LEVEL_EN
    ,
    output logic [BYTE_FIFO_LEVEL_WIDTH-1:0] level,
    output logic                             almost_full
`endif
);

    fifo_state_t state_q;
    fifo_state_t state_d;
    logic        ram_full;
    logic        ram_empty;
    logic        push;
    logic        pop;
    logic        fetch;

    assign ram_full  = (state_q.ram_count == FIFO_FULL_COUNT);
    assign ram_empty = (state_q.ram_count == '0);
    assign in_ready  = ~ram_full;
    assign out_valid = state_q.out_valid;

    // Fetch only looks at the registered count, so a byte is never read
    // back in the same cycle it is written.
    assign push  = in_valid & ~ram_full & ~flush & ~reset;
    assign pop   = state_q.out_valid & out_ready;
    assign fetch = (~state_q.out_valid | out_ready) & ~ram_empty & ~flush & ~reset;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = '0;
        end else begin
            if (push) begin
                state_d.wr_ptr = state_q.wr_ptr + PTR_ONE;
            end
            if (fetch) begin
                state_d.rd_ptr = state_q.rd_ptr + PTR_ONE;
            end
            unique case ({push, fetch})
                2'b10:   state_d.ram_count = state_q.ram_count + COUNT_ONE;
                2'b01:   state_d.ram_count = state_q.ram_count - COUNT_ONE;
                default: state_d.ram_count = state_q.ram_count;
            endcase
            if (fetch) begin
                state_d.out_valid = 1'b1;
            end else if (pop) begin
                state_d.out_valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef BYTE_FIFO_LEVEL_EN
    localparam fifo_count_t ALMOST_FULL_COUNT = fifo_count_t'(ALMOST_FULL_LEVEL);

    fifo_count_t level_d;

    assign level_d = fifo_level(state_d.ram_count, state_d.out_valid);

    // Registered from next-state so level tracks the state on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            level       <= '0;
            almost_full <= 1'b0;
        end else begin
            level       <= level_d;
            almost_full <= (level_d >= ALMOST_FULL_COUNT);
        end
    end
`endif

    dual_port_memory #(
        .DEPTH      (BYTE_FIFO_DEPTH),
        .ADDR_WIDTH (BYTE_FIFO_ADDR_WIDTH),
        .DATA_WIDTH (BYTE_FIFO_DATA_WIDTH)
    ) u_memory (
        .write_clock        (clock),
        .write_clock_enable (1'b1),
        .write_enable       (push),
        .write_addr         (state_q.wr_ptr),
        .write_data         (in_data),
        .read_clock         (clock),
        .read_clock_enable  (1'b1),
        .read_enable        (fetch),
        .read_addr          (state_q.rd_ptr),
        .read_data          (out_data)
    );

endmodule
